// File: rtl/sram_arbiter.sv
// sram_arbiter: time-division sharing of one asynchronous SRAM between a
// fixed-latency scan-out read port (even slots) and a buffered pixel-write
// port (odd slots and any cycle without a read request).
module sram_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_ack,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [ADDR_W-1:0]             sram_addr,
  inout  wire  [DATA_W-1:0]             sram_dq,
  output logic                          sram_we_n,
  output logic                          sram_oe_n,
  output logic                          sram_ce_n,
  output logic                          sram_ub_n,
  output logic                          sram_lb_n
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  logic [1:0]        rst_sync_r;
  logic              phase_r;
  op_t               op_r;
  logic [ENT_W-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [DATA_W-1:0] dq_out_r;
  logic              dq_oe_r;

  logic              issue_en_s;
  logic              run_s;
  logic              push_s;
  logic              do_read_s;
  logic              do_write_s;
  logic [ENT_W-1:0]  head_s;

  // Reset release synchronizer; assertion is asynchronous, release takes two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Slot phase: 0 after reset, toggles every cycle; phase 0 cycles are read slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
    end else begin
      phase_r <= ~phase_r;
    end
  end

  // Operation select for the cycle after the coming edge, plus FIFO handshake.
  always_comb begin
    issue_en_s = rst_sync_r[0];
    run_s      = rst_sync_r[1];
    head_s     = mem_r[rd_ptr_r];
    fifo_level = level_r;
    if (run_s && (level_r < DEPTH_LVL)) begin
      wr_ready = 1'b1;
    end else begin
      wr_ready = 1'b0;
    end
    push_s = wr_valid & wr_ready;
    // Next phase is 0 exactly when the current phase is 1.
    if (issue_en_s && phase_r && rd_req) begin
      do_read_s  = 1'b1;
      do_write_s = 1'b0;
    end else if (issue_en_s && (level_r != {LVL_W{1'b0}})) begin
      do_read_s  = 1'b0;
      do_write_s = 1'b1;
    end else begin
      do_read_s  = 1'b0;
      do_write_s = 1'b0;
    end
    rd_ack = do_read_s;
  end

  // Write-buffer storage; entries need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {wr_addr, wr_data};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Write-buffer pointers and occupancy; reset discards pending entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_write_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, do_write_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // SRAM operation FSM with registered strobes, address, data and read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= OP_IDLE;
      sram_addr <= {ADDR_W{1'b0}};
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_ce_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
      dq_out_r  <= {DATA_W{1'b0}};
      dq_oe_r   <= 1'b0;
      rd_data   <= {DATA_W{1'b0}};
      rd_valid  <= 1'b0;
    end else begin
      sram_ce_n <= ~issue_en_s;
      sram_ub_n <= ~issue_en_s;
      sram_lb_n <= ~issue_en_s;
      if (op_r == OP_READ) begin
        rd_data  <= sram_dq;
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
      if (do_read_s) begin
        op_r      <= OP_READ;
        sram_addr <= rd_addr;
        sram_oe_n <= 1'b0;
        sram_we_n <= 1'b1;
        dq_oe_r   <= 1'b0;
      end else if (do_write_s) begin
        op_r      <= OP_WRITE;
        sram_addr <= head_s[ENT_W-1:DATA_W];
        dq_out_r  <= head_s[DATA_W-1:0];
        sram_oe_n <= 1'b1;
        sram_we_n <= 1'b0;
        dq_oe_r   <= 1'b1;
      end else begin
        op_r      <= OP_IDLE;
        sram_oe_n <= 1'b1;
        sram_we_n <= 1'b1;
        dq_oe_r   <= 1'b0;
      end
    end
  end

  // Data bus is driven only during write cycles, which never overlap oe_n=0.
  assign sram_dq = dq_oe_r ? dq_out_r : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based slot model.
module tb_sram_arbiter;
  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ack, rd_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic [3:0]    fifo_level;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic          sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .fifo_level(fifo_level),
    .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // SRAM content seen by reads: fixed function of address (0x00010 -> 0xA5A5).
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hA5B5;
  endfunction

  assign sram_dq = (!sram_oe_n && !sram_ce_n && sram_we_n) ? rd_fn(sram_addr) : {DW{1'bz}};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since release, write queue, expected bus state.
  int                 m_n;
  logic [AW+DW-1:0]   m_q[$];
  logic               m_cur_read;
  logic               exp_we_n, exp_oe_n, exp_rd_valid;
  logic [AW-1:0]      exp_addr;
  logic [DW-1:0]      exp_dq, exp_rd_data;

  task automatic model_reset();
    m_n = 0;
    m_q.delete();
    m_cur_read = 1'b0;
    exp_we_n = 1'b1; exp_oe_n = 1'b1; exp_rd_valid = 1'b0;
    exp_addr = '0; exp_dq = '0; exp_rd_data = '0;
  endtask

  task automatic model_edge();
    logic             ready_before;
    logic [AW+DW-1:0] e;
    ready_before = (m_n >= 2) && (m_q.size() < DEPTH);
    m_n++;
    exp_rd_valid = m_cur_read;
    if (m_cur_read) exp_rd_data = rd_fn(exp_addr);
    m_cur_read = 1'b0;
    exp_we_n = 1'b1;
    exp_oe_n = 1'b1;
    if (m_n >= 2 && (m_n % 2) == 0 && rd_req) begin
      m_cur_read = 1'b1;
      exp_oe_n = 1'b0;
      exp_addr = rd_addr;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      exp_we_n = 1'b0;
      exp_addr = e[AW+DW-1:DW];
      exp_dq = e[DW-1:0];
    end
    if (wr_valid && ready_before) m_q.push_back({wr_addr, wr_data});
  endtask

  task automatic compare();
    chk("we_n", 32'(sram_we_n), 32'(exp_we_n));
    chk("oe_n", 32'(sram_oe_n), 32'(exp_oe_n));
    chk("ce_n", 32'(sram_ce_n), 32'(m_n < 2));
    chk("ub_n", 32'(sram_ub_n), 32'(m_n < 2));
    chk("lb_n", 32'(sram_lb_n), 32'(m_n < 2));
    chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
    chk("fifo_level", 32'(fifo_level), m_q.size());
    chk("wr_ready", 32'(wr_ready), 32'((m_n >= 2) && (m_q.size() < DEPTH)));
    chk("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
    chk("rd_data", 32'(rd_data), 32'(exp_rd_data));
    if (!exp_we_n) chk("dq_write", 32'(sram_dq), 32'(exp_dq));
    chk("oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 32'd0);
  endtask

  // One clock: check rd_ack on current inputs, advance model at the edge, compare.
  task automatic step();
    #1;
    chk("rd_ack", 32'(rd_ack), 32'(rst_n && ((m_n + 1) >= 2) && (((m_n + 1) % 2) == 0) && rd_req));
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    compare();
  endtask

  typedef struct {
    logic          wv;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          we_n;
    logic          oe_n;
    logic [AW-1:0] addr;
    int            level;
    logic          ready;
    logic          rvalid;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  we_cnt, first_low, last_low, max_lvl, ready_toggles, found;
    logic prev_ready;

    // Interleave vectors from reset release, rd_req=1 at 0x00010 throughout.
    tbl[0]  = '{1'b0, 18'h0,     16'h0,    1'b1, 1'b1, 18'h0,     0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 18'h0,     16'h0,    1'b1, 1'b0, 18'h00010, 0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 18'h00100, 16'h1111, 1'b1, 1'b1, 18'h00010, 1, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 18'h00101, 16'h2222, 1'b1, 1'b0, 18'h00010, 2, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 18'h00102, 16'h3333, 1'b0, 1'b1, 18'h00100, 2, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 18'h0,     16'h0,    1'b1, 1'b0, 18'h00010, 2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 18'h0,     16'h0,    1'b0, 1'b1, 18'h00101, 1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 18'h0,     16'h0,    1'b1, 1'b0, 18'h00010, 1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 18'h0,     16'h0,    1'b0, 1'b1, 18'h00102, 0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 18'h0,     16'h0,    1'b1, 1'b0, 18'h00010, 0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 18'h0,     16'h0,    1'b1, 1'b1, 18'h00010, 0, 1'b1, 1'b1};

    // Reset held with both requesters active: outputs at reset values, no growth.
    model_reset();
    rst_n = 1'b0; rd_req = 1'b1; rd_addr = 18'h00010;
    wr_valid = 1'b1; wr_addr = 18'h3FFFF; wr_data = 16'hDEAD;
    @(negedge clk);
    repeat (4) step();

    // Release and run the vector table.
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wr_valid = tbl[i].wv; wr_addr = tbl[i].waddr; wr_data = tbl[i].wdata;
      step();
      chk("tbl_we_n", 32'(sram_we_n), 32'(tbl[i].we_n));
      chk("tbl_oe_n", 32'(sram_oe_n), 32'(tbl[i].oe_n));
      chk("tbl_addr", 32'(sram_addr), 32'(tbl[i].addr));
      chk("tbl_level", 32'(fifo_level), tbl[i].level);
      chk("tbl_ready", 32'(wr_ready), 32'(tbl[i].ready));
      chk("tbl_rd_valid", 32'(rd_valid), 32'(tbl[i].rvalid));
      if (tbl[i].rvalid) chk("tbl_rd_data", 32'(rd_data), 32'h0000A5A5);
    end

    // Blanking drain: eight back-to-back pushes drain on eight consecutive cycles.
    rd_req = 1'b0;
    we_cnt = 0; first_low = -1; last_low = -1; found = 0;
    for (int i = 0; i < 12; i++) begin
      wr_valid = (i < 8); wr_addr = 18'h00200 + 18'(i); wr_data = 16'($urandom);
      if (!wr_ready && i < 8) found = 1;
      step();
      if (!sram_we_n) begin
        we_cnt++;
        if (first_low < 0) first_low = i;
        last_low = i;
      end
    end
    chk("drain_count", we_cnt, 8);
    chk("drain_consecutive", last_low - first_low + 1, 8);
    chk("drain_ready_low", found, 0);

    // Backpressure: continuous reads with a write offered every cycle.
    rd_req = 1'b1; wr_valid = 1'b1; wr_addr = 18'h01000;
    max_lvl = 0; ready_toggles = 0; prev_ready = wr_ready;
    for (int i = 0; i < 48; i++) begin
      wr_data = 16'($urandom); rd_addr = 18'($urandom);
      found = int'(wr_ready);
      step();
      if (found != 0) wr_addr = wr_addr + 18'd1;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (wr_ready != prev_ready) ready_toggles++;
      prev_ready = wr_ready;
    end
    chk("bp_max_level", max_lvl, 8);
    chk("bp_ready_toggles", 32'(ready_toggles >= 4), 32'd1);
    wr_valid = 1'b0;
    repeat (20) step();
    chk("bp_drained", 32'(fifo_level), 32'd0);

    // Randomized traffic with varying read density.
    for (int i = 0; i < 1500; i++) begin
      if (i < 500) rd_req = ($urandom_range(0, 3) != 0);
      else if (i < 1000) rd_req = ($urandom_range(0, 3) == 0);
      else rd_req = ($urandom_range(0, 1) == 1);
      rd_addr = 18'($urandom); wr_valid = ($urandom_range(0, 2) != 0);
      wr_addr = 18'($urandom); wr_data = 16'($urandom);
      step();
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    repeat (12) step();

    // Reset during a write cycle with several entries queued.
    rd_req = 1'b1; found = 0;
    for (int i = 0; i < 40; i++) begin
      wr_valid = 1'b1; wr_addr = 18'h02000 + 18'(i); wr_data = 16'($urandom);
      step();
      if (!sram_we_n && fifo_level >= 4'd5) begin
        found = 1;
        break;
      end
    end
    chk("midwrite_reached", found, 1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_we_n", 32'(sram_we_n), 32'd1);
    chk("async_oe_n", 32'(sram_oe_n), 32'd1);
    chk("async_ce_n", 32'(sram_ce_n), 32'd1);
    chk("async_level", 32'(fifo_level), 32'd0);
    chk("async_ready", 32'(wr_ready), 32'd0);
    chk("async_addr", 32'(sram_addr), 32'd0);
    wr_valid = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    repeat (3) step();
    rst_n = 1'b1;
    we_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!sram_we_n) we_cnt++;
    end
    chk("post_reset_writes", we_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
